// File: rtl/lsu_pkg.sv
// lsu_pkg: shared constants and types for the load/store unit.
//   LSU_XLEN        - data/address width (only 32 supported)
//   F3_*            - RISC-V load/store funct3 width/sign codes
//   lsu_state_t     - LSU transfer FSM states
//   lsu_illegal()   - misaligned / illegal-funct3 detection
//   lsu_be()        - byte enables for a given size and byte offset
package lsu_pkg;

    localparam int LSU_XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    // Unsigned variants exist only for loads; 011/110/111 are never legal.
    function automatic logic lsu_illegal(input logic we, input logic [2:0] f3,
                                         input logic [1:0] off);
        case (f3)
            F3_B:    return 1'b0;
            F3_BU:   return we;
            F3_H:    return off[0];
            F3_HU:   return we | off[0];
            F3_W:    return off != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    // funct3[1:0] encodes the access size for both signed and unsigned codes.
    function automatic logic [3:0] lsu_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// lsu_if: req/gnt/rvalid data-memory bus.
//   mem_req/we/be/addr/wdata - request side, driven by the LSU (master)
//   mem_gnt                  - request accepted by memory
//   mem_rvalid/mem_rdata     - response (read data for loads, ack for stores)
interface lsu_if;
    import lsu_pkg::*;

    logic                mem_req;
    logic                mem_we;
    logic [3:0]          mem_be;
    logic [LSU_XLEN-1:0] mem_addr;
    logic [LSU_XLEN-1:0] mem_wdata;
    logic                mem_gnt;
    logic                mem_rvalid;
    logic [LSU_XLEN-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/lsu_align.sv
// lsu_align: combinational load extraction.
//   rdata_i  - full bus word
//   off_i    - byte offset addr[1:0]
//   funct3_i - load width/sign code
//   data_o   - addressed byte/half/word, sign- or zero-extended to XLEN
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = LSU_XLEN
) (
    input  logic [XLEN-1:0] rdata_i,
    input  logic [1:0]      off_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[{off_i, 3'b000} +: 8];
        half_sel = rdata_i[{off_i[1], 4'b0000} +: 16];
        case (funct3_i)
            F3_B:    data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_BU:   data_o = {{(XLEN-8){1'b0}}, byte_sel};
            F3_H:    data_o = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_HU:   data_o = {{(XLEN-16){1'b0}}, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// lsu: RV32I MEM-stage load/store unit.
//   clk, rst_n        - core clock, async active-low reset
//   req_*_i           - load/store request from EX/MEM
//   stall_o           - hold pipeline while a transfer is pending
//   done_o            - one-cycle completion pulse
//   load_data_o       - registered, extended load result
//   err_o             - misaligned / illegal request (IDLE only, combinational)
//   mem               - data-memory bus (master side)
module lsu
    import lsu_pkg::*;
#(
    parameter int XLEN = LSU_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid_i,
    input  logic            req_we_i,
    input  logic [2:0]      req_funct3_i,
    input  logic [XLEN-1:0] req_addr_i,
    input  logic [XLEN-1:0] req_wdata_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] load_data_o,
    output logic            err_o,
    lsu_if.master           mem
);

    lsu_state_t      state_q;
    logic            req_q, busy_q, done_q, we_q;
    logic [2:0]      f3_q;
    logic [1:0]      off_q;
    logic [3:0]      be_q;
    logic [XLEN-1:0] addr_q, wdata_q, ld_q;

    logic            illegal, accept;
    logic [XLEN-1:0] wdata_fmt, ld_ext;

    assign illegal = lsu_illegal(req_we_i, req_funct3_i, req_addr_i[1:0]);
    assign err_o   = (state_q == IDLE) && req_valid_i && illegal;
    assign accept  = (state_q == IDLE) && req_valid_i && !illegal;
    // busy_q covers REQ and WAIT; the IDLE term lets the stall start in the accept cycle.
    assign stall_o = accept | busy_q;

    // Replicate narrow store data across lanes; byte enables pick the live lane.
    always_comb begin
        case (req_funct3_i[1:0])
            2'b00:   wdata_fmt = {4{req_wdata_i[7:0]}};
            2'b01:   wdata_fmt = {2{req_wdata_i[15:0]}};
            default: wdata_fmt = req_wdata_i;
        endcase
    end

    lsu_align #(.XLEN(XLEN)) u_align (
        .rdata_i  (mem.mem_rdata),
        .off_i    (off_q),
        .funct3_i (f3_q),
        .data_o   (ld_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            off_q   <= 2'b00;
            be_q    <= 4'b0000;
            addr_q  <= '0;
            wdata_q <= '0;
            ld_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        we_q    <= req_we_i;
                        f3_q    <= req_funct3_i;
                        off_q   <= req_addr_i[1:0];
                        addr_q  <= {req_addr_i[XLEN-1:2], 2'b00};
                        be_q    <= lsu_be(req_funct3_i, req_addr_i[1:0]);
                        wdata_q <= wdata_fmt;
                        req_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (mem.mem_gnt) begin
                        req_q   <= 1'b0;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem.mem_rvalid) begin
                        if (!we_q) ld_q <= ld_ext;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign done_o        = done_q;
    assign load_data_o   = ld_q;
    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_be    = be_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

endmodule
